// File: rtl/fp_add_pkg.sv
// Shared widths and encodings for the FP32 adder normaliser.
package fp_add_pkg;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int MANT_W     = 50;
  localparam int HIDDEN_POS = 47;
  localparam int GRS_LSB    = 23;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
endpackage

// File: rtl/fp_add_normalizer_lzc50.sv
// Combinational leading-zero count of the 49-bit magnitude field.
module lzc50
  import fp_add_pkg::*;
(
  input  logic [MANT_W-2:0] vec,
  output logic [5:0]        count,
  output logic              zero
);
  // Later (higher) set bits override earlier ones, so the MSB-most one wins.
  always_comb begin
    count = 6'd49;
    for (int i = 0; i < MANT_W - 1; i++) begin
      if (vec[i]) count = 6'(MANT_W - 2 - i);
    end
  end

  assign zero = ~|vec;
endmodule

// File: rtl/fp_add_normalizer.sv
// Add, normalise, round-to-nearest-even and pack an FP32 sum in three stages.
// Define FP_ADD_FLAGS_EN to add the registered IEEE exception flags output.
module fp_add_normalizer
  import fp_add_pkg::*;
#(
  parameter int PIPE_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              NaN_res,
  input  logic              inf_res,
  input  logic              res_sig,
  input  logic [EXP_W-1:0]  exp_max,
  input  logic [MANT_W-1:0] mant_op_1,
  input  logic [MANT_W-1:0] mant_op_2,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FP_ADD_FLAGS_EN
  output logic [3:0]        flags,
`endif
  output logic [31:0]       res
);
  logic [PIPE_STAGES-1:0] valid;
  logic [PIPE_STAGES:0]   ready;

  assign ready[PIPE_STAGES] = out_ready;
  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_ready
    assign ready[gi] = ~valid[gi] | ready[gi+1];
  end
  assign in_ready  = ready[0];
  assign out_valid = valid[PIPE_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (ready[0]) valid[0] <= in_valid;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (ready[k]) valid[k] <= valid[k-1];
      end
    end
  end

  logic [MANT_W-1:0] s1_sum;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_sign, s1_nan, s1_inf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum <= '0; s1_exp <= '0; s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0;
    end else if (in_valid && ready[0]) begin
      s1_sum  <= mant_op_1 + mant_op_2;
      s1_exp  <= (exp_max == '0) ? 8'd1 : exp_max;
      s1_sign <= res_sig;
      s1_nan  <= NaN_res;
      s1_inf  <= inf_res;
    end
  end

  // The preparer keeps the sum non-negative, so bit 49 carries no information.
  logic sum_msb_unused;
  assign sum_msb_unused = s1_sum[MANT_W-1];

  logic [5:0]            lz, lz_m1, sh;
  logic                  all_zero;
  logic [EXP_W-1:0]      exp_m1;
  logic [HIDDEN_POS:0]   n_next;
  logic [EXP_W:0]        e_next;

  lzc50 u_lzc (.vec(s1_sum[MANT_W-2:0]), .count(lz), .zero(all_zero));

  always_comb begin
    lz_m1  = lz - 6'd1;
    exp_m1 = s1_exp - 8'd1;
    sh     = '0;
    n_next = '0;
    e_next = '0;
    if (all_zero) begin
      e_next = '0;
    end else if (lz == 6'd0) begin
      n_next = {s1_sum[48:2], s1_sum[1] | s1_sum[0]};
      e_next = {1'b0, s1_exp} + 9'd1;
    end else begin
      // Left shift is capped so the exponent never drops below 1.
      sh     = ({2'b0, lz_m1} <= exp_m1) ? lz_m1 : exp_m1[5:0];
      n_next = s1_sum[HIDDEN_POS:0] << sh;
      e_next = {1'b0, s1_exp} - {3'b0, sh};
      if (!n_next[HIDDEN_POS]) e_next = '0;
    end
  end

  logic [HIDDEN_POS:0] s2_n;
  logic [EXP_W:0]      s2_e;
  logic                s2_sign, s2_nan, s2_inf, s2_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_n <= '0; s2_e <= '0; s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0; s2_zero <= 1'b0;
    end else if (valid[0] && ready[1]) begin
      s2_n    <= n_next;
      s2_e    <= e_next;
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= all_zero;
    end
  end

  logic [23:0]       m;
  logic              g, s, up, ovf;
  logic [24:0]       m_r;
  logic [EXP_W:0]    e_r;
  logic [FRAC_W-1:0] frac;
  logic [31:0]       res_next;

  always_comb begin
    m    = s2_n[HIDDEN_POS:GRS_LSB+1];
    g    = s2_n[GRS_LSB];
    s    = |s2_n[GRS_LSB-1:0];
    up   = g & (s | m[0]);
    m_r  = {1'b0, m} + {24'b0, up};
    if (m_r[24]) begin
      frac = m_r[23:1];
      e_r  = s2_e + 9'd1;
    end else begin
      frac = m_r[22:0];
      // A denormal that rounds up into the hidden bit becomes the smallest normal.
      e_r  = (s2_e == '0 && m_r[23]) ? 9'd1 : s2_e;
    end
    ovf = (e_r >= 9'd255);
    if (s2_nan)                res_next = QNAN;
    else if (s2_inf || ovf)    res_next = {s2_sign, EXP_INF, 23'b0};
    else if (s2_zero)          res_next = {s2_sign, 31'b0};
    else                       res_next = {s2_sign, e_r[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      res <= '0;
    else if (valid[1] && ready[2])   res <= res_next;
  end

`ifdef FP_ADD_FLAGS_EN
  logic [3:0] flags_next;
  always_comb begin
    flags_next    = '0;
    flags_next[0] = g | s;
    flags_next[1] = ovf & ~s2_inf & ~s2_nan;
    flags_next[2] = (s2_e == '0) & ~s2_zero & (g | s);
    flags_next[3] = s2_nan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      flags <= '0;
    else if (valid[1] && ready[2])   flags <= flags_next;
  end
`endif
endmodule

// File: tb/tb_fp_add_normalizer.sv
// Scoreboard bench for fp_add_normalizer: directed arithmetic, throughput, stall and reset.
module tb_fp_add_normalizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        NaN_res = 1'b0;
  logic        inf_res = 1'b0;
  logic        res_sig = 1'b0;
  logic [7:0]  exp_max = 8'd0;
  logic [49:0] mant_op_1 = '0;
  logic [49:0] mant_op_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic [3:0]  cur_flags;

`ifdef FP_ADD_FLAGS_EN
  logic [3:0] flags;
  assign cur_flags = flags;
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  assign cur_flags = 4'h0;
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  fp_add_normalizer #(.PIPE_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .NaN_res(NaN_res), .inf_res(inf_res), .res_sig(res_sig), .exp_max(exp_max),
    .mant_op_1(mant_op_1), .mant_op_2(mant_op_2), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FP_ADD_FLAGS_EN
    .flags(flags),
`endif
    .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nan, inf, sg;
    logic [7:0]  e;
    logic [49:0] a, b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  localparam logic [49:0] ONE = 50'd1;
  localparam logic [49:0] P47 = ONE << 47;
  localparam logic [49:0] P46 = ONE << 46;

  vec_t        vq[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          passed = 0;
  int          total  = 0;

  task automatic drive(input vec_t v);
    NaN_res = v.nan; inf_res = v.inf; res_sig = v.sg;
    exp_max = v.e; mant_op_1 = v.a; mant_op_2 = v.b;
  endtask

  // One clock: inputs are already set; handshakes are sampled at the falling edge.
  task automatic tick(input logic [35:0] ev, output logic acc);
    @(negedge clk); #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ev);
    if (out_valid && out_ready) got_q.push_back({res, cur_flags});
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   n = 0;
    in_valid = 1'b0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      tick(36'h0, acc);
      n++;
    end
  endtask

  function automatic vec_t mk(input logic nan, inf, sg, input logic [7:0] e,
                              input logic [49:0] a, b, input logic [31:0] r,
                              input logic [3:0] f);
    vec_t v;
    v.nan = nan; v.inf = inf; v.sg = sg; v.e = e; v.a = a; v.b = b; v.r = r; v.f = f;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid);
    else passed++;
    total++;
    if (res !== 32'h0) $display("FAIL reset_res got %h expected 00000000", res);
    else passed++;
`ifdef FP_ADD_FLAGS_EN
    total++;
    if (flags !== 4'h0) $display("FAIL reset_flags got %h expected 0", flags);
    else passed++;
`endif
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready);
    else begin passed++; $display("ok reset state"); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    vec_t        v;
    logic        acc = 1'b0;
    int          lat = 0;
    logic [35:0] ev, gv;
    v = mk(0, 0, 0, 8'd127, P47, P47, 32'h40000000, 4'h0);
    out_ready = 1'b1;
    drive(v); in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) tick({v.r, v.f & FLAG_MASK}, acc);
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(36'h0, acc);
      if (got_q.size() > 0) begin lat = i; break; end
    end
    total++;
    if (lat != 3) $display("FAIL latency got %0d cycles expected 3", lat);
    else passed++;
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); total++;
      if (got_q.size() == 0) $display("FAIL one_plus_one got nothing expected %h", ev);
      else begin
        gv = got_q.pop_front();
        if (gv !== ev) $display("FAIL one_plus_one got %h expected %h", gv, ev);
        else begin passed++; $display("ok one_plus_one res/flags %h latency %0d", gv, lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          idx = 0, cycles = 0;
    logic        acc;
    logic [35:0] ev, gv;
    vq.delete();
    vq.push_back(mk(0, 0, 0, 8'd127, P47 + (ONE << 24) + (ONE << 23), '0, 32'h3F800002, 4'b0001));
    vq.push_back(mk(0, 0, 0, 8'd254, P47, P47, 32'h7F800000, 4'b0010));
    vq.push_back(mk(1, 0, 0, 8'd127, '0, '0, 32'h7FC00000, 4'b1000));
    vq.push_back(mk(0, 1, 1, 8'd127, '0, '0, 32'hFF800000, 4'b0000));
    vq.push_back(mk(0, 0, 1, 8'd127, P47, 50'd0 - P47, 32'h80000000, 4'b0000));
    vq.push_back(mk(0, 0, 0, 8'd127, P46, '0, 32'h3F000000, 4'b0000));
    vq.push_back(mk(0, 0, 0, 8'd0, P46, '0, 32'h00400000, 4'b0000));
    vq.push_back(mk(0, 0, 0, 8'd0, (((ONE << 23) - ONE) << 24) + (ONE << 23), '0, 32'h00800000, 4'b0101));
    vq.push_back(mk(0, 0, 0, 8'd127, (((ONE << 24) - ONE) << 24) + (ONE << 23), '0, 32'h40000000, 4'b0001));
    vq.push_back(mk(0, 0, 0, 8'd127, (ONE << 48) + ONE, '0, 32'h40000000, 4'b0001));
    vq.push_back(mk(0, 0, 0, 8'd3, ONE << 40, '0, 32'h00040000, 4'b0000));
    vq.push_back(mk(0, 0, 0, 8'd127, P47 + P46, 50'd0 - P46, 32'h3F800000, 4'b0000));
    out_ready = 1'b1;
    while (idx < vq.size() && cycles < 100) begin
      drive(vq[idx]); in_valid = 1'b1;
      tick({vq[idx].r, vq[idx].f & FLAG_MASK}, acc);
      if (acc) idx++;
      cycles++;
    end
    drain(50);
    total++;
    if (cycles != vq.size()) $display("FAIL throughput got %0d cycles expected %0d", cycles, vq.size());
    else passed++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      ev = exp_q.pop_front(); total++;
      if (got_q.size() == 0) $display("FAIL directed_%0d got nothing expected %h", i, ev);
      else begin
        gv = got_q.pop_front();
        if (gv !== ev) $display("FAIL directed_%0d got %h expected %h", i, gv, ev);
        else begin passed++; $display("ok directed_%0d res/flags %h", i, gv); end
      end
    end
    total++;
    if (got_q.size() != 0) $display("FAIL directed_extra got %0d results expected 0", got_q.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    int          idx = 0, guard = 0;
    logic        acc, have_held = 1'b0, changed = 1'b0;
    logic [31:0] held = '0;
    logic [35:0] ev, gv;
    vec_t        v;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      v = mk(0, 0, 0, 8'(100 + idx), P47, P47, {1'b0, 8'(101 + idx), 23'b0}, 4'h0);
      if (idx < 5) begin drive(v); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick({v.r, v.f}, acc);
      if (acc) idx++;
      if (out_valid) begin
        if (!have_held) begin held = res; have_held = 1'b1; end
        else if (res !== held) changed = 1'b1;
      end
    end
    total++;
    if (idx != 3) $display("FAIL bp_accepts got %0d expected 3", idx);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %b expected 0", in_ready);
    else passed++;
    total++;
    if (!have_held || changed) $display("FAIL bp_res_stable got changed=%b held=%b expected changed=0 held=1", changed, have_held);
    else passed++;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_push_pop_full got in_ready %b expected 1", in_ready);
    else passed++;
    while (idx < 5 && guard < 50) begin
      v = mk(0, 0, 0, 8'(100 + idx), P47, P47, {1'b0, 8'(101 + idx), 23'b0}, 4'h0);
      drive(v); in_valid = 1'b1;
      tick({v.r, v.f}, acc);
      if (acc) idx++;
      guard++;
    end
    drain(50);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ev = exp_q.pop_front(); total++;
      if (got_q.size() == 0) $display("FAIL bp_item_%0d got nothing expected %h", i, ev);
      else begin
        gv = got_q.pop_front();
        if (gv !== ev) $display("FAIL bp_item_%0d got %h expected %h", i, gv, ev);
        else begin passed++; $display("ok bp_item_%0d res/flags %h", i, gv); end
      end
    end
    total++;
    if (got_q.size() != 0) $display("FAIL bp_extra got %0d results expected 0", got_q.size());
    else passed++;
  endtask

  task automatic test_reset_midstream();
    int          idx = 0, guard = 0;
    logic        acc;
    logic [35:0] ev, gv;
    vec_t        v;
    out_ready = 1'b0;
    while (idx < 3 && guard < 20) begin
      v = mk(0, 0, 1, 8'(50 + idx), P47, P47, {1'b1, 8'(51 + idx), 23'b0}, 4'h0);
      drive(v); in_valid = 1'b1;
      tick({v.r, v.f}, acc);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL rst_mid_in_flight got out_valid %b expected 1", out_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || res !== 32'h0)
      $display("FAIL rst_mid_flush got out_valid %b res %h expected 0 00000000", out_valid, res);
    else passed++;
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b expected 1", in_ready);
    else passed++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    v = mk(0, 0, 0, 8'd126, P47, P47, 32'h3F800000, 4'h0);
    drive(v); in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick({v.r, v.f}, acc);
    drain(20);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); total++;
      if (got_q.size() == 0) $display("FAIL rst_mid_after got nothing expected %h", ev);
      else begin
        gv = got_q.pop_front();
        if (gv !== ev) $display("FAIL rst_mid_after got %h expected %h", gv, ev);
        else begin passed++; $display("ok rst_mid_after res/flags %h", gv); end
      end
    end
    total++;
    if (got_q.size() != 0) $display("FAIL rst_mid_stale got %0d results expected 0", got_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Downstream stage of the FP32 adder operand preparer.
- Takes the aligned 50-bit mantissas, max exponent, result sign and special-case flags from the preparer.
- Adds the mantissas, normalises and rounds (round-to-nearest-even), then packs an IEEE-754 single result.
- 3-stage valid/ready pipeline; final stage before the adder's result register.

Parameters:
- PIPE_STAGES, 3, fixed pipeline depth; the only legal value is 3, documented for the bench.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  preparer outputs valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- NaN_res  in  1  result is NaN.
- inf_res  in  1  result is infinity.
- res_sig  in  1  result sign.
- exp_max  in  8  larger biased exponent field.
- mant_op_1  in  50  aligned two's-complement mantissa, hidden bit at [47], guard/sticky field at [23:0].
- mant_op_2  in  50  same layout as mant_op_1.
- out_valid  out  1  res valid.
- out_ready  in  1  consumer accepts res.
- res  out  32  packed FP32 result.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, res = 0. in_ready is combinational and equals 1 after reset.
- Handshake:
  - Stage k advances when valid_k = 0 or ready_{k+1} = 1; ready_4 = out_ready.
  - in_ready = ready_1.
  - Transfer happens on in_valid & in_ready and on out_valid & out_ready.
  - res is held stable while out_valid & ~out_ready.
  - No drops, no duplicates, order preserved.
- Latency: 3 cycles from accept to out_valid when out_ready = 1. Throughput is 1 per cycle.
- S1 (add):
  - sum = mant_op_1 + mant_op_2, mod 2^50.
  - The preparer guarantees sum[49] = 0; the block does not check this.
  - eff_exp = (exp_max == 0) ? 1 : exp_max.
  - Register sum, eff_exp, res_sig, NaN_res, inf_res.
- S2 (normalise):
  - p = index of the leading one in sum[48:0] (leading-zero count).
  - p = 48: shift right 1, OR the shifted-out bit into [0]; E = eff_exp + 1.
  - p ≤ 47: sh = min(47 − p, eff_exp − 1); shift left by sh; E = eff_exp − sh.
  - If bit [47] is 0 after the shift, E = 0 (denormal).
  - sum = 0: zero flag set, E = 0.
- S3 (round and pack):
  - m = n[47:24], G = n[23], S = |n[22:0].
  - Round up when G & (S | m[0]).
  - Rounding carry to 2^24: m >>= 1, E += 1.
  - Denormal rounding into bit [23] sets E = 1.
  - E ≥ 255 → infinity.
- Output priority:
  1. NaN_res → 0x7FC00000.
  2. inf_res or overflow → {res_sig, 0xFF, 23'b0}.
  3. zero → {res_sig, 31'b0}.
  4. else → {res_sig, E[7:0], m[22:0]}.
- Boundaries:
  - Full pipe with out_ready = 0: in_ready = 0 in the same cycle.
  - Simultaneous output pop and input push when full: both complete and occupancy is unchanged.
  - Reset asserted mid-operation: all in-flight results are discarded immediately (asynchronous).

Optional Feature:
- FP_ADD_FLAGS_EN defined: adds output port flags[3:0], registered alongside res and reset to 0.
  - [0] inexact: G | S.
  - [1] overflow: rounding or normalisation reached E ≥ 255 with no inf_res/NaN_res.
  - [2] underflow: denormal result and inexact.
  - [3] invalid: NaN_res.
- Undefined: no flags port, no flag logic.

Decomposition:
- Package fp_add_pkg:
  - EXP_W = 8, FRAC_W = 23, MANT_W = 50, HIDDEN_POS = 47, GRS_LSB = 23.
  - QNAN = 32'h7FC00000, EXP_INF = 8'hFF.
- One sub-module, lzc50: combinational leading-zero count of a 49-bit vector, 6-bit count output plus an all-zero flag.

Test Plan:
- 1.0 + 1.0:
  - Stimulus: mant_op_1 = mant_op_2 = 2^47, exp_max = 127, res_sig = 0, out_ready = 1.
  - Required: res = 0x40000000, 3 cycles after accept.
- Rounding tie to even:
  - Stimulus: mant_op_1 = 2^47 + 2^24 + 2^23, mant_op_2 = 0, exp_max = 127.
  - Required: res = 0x3F800002.
- Overflow:
  - Stimulus: both mantissas 2^47, exp_max = 254.
  - Required: res = 0x7F800000; flags[1] = 1 when FP_ADD_FLAGS_EN is defined.
- Special cases:
  - NaN_res = 1 → res = 0x7FC00000.
  - inf_res = 1, res_sig = 1 → res = 0xFF800000.
  - mant_op_1 = −mant_op_2 → res = {res_sig, 31'b0}.
- Backpressure:
  - Stimulus: out_ready = 0 for 6 cycles while pushing 5 distinct inputs back-to-back.
  - Required: in_ready falls after 3 accepts; after release, all accepted results appear in order with none lost; res is stable while stalled.
- Reset mid-stream:
  - Stimulus: rst_n pulsed low with 3 items in flight.
  - Required: out_valid = 0 and res = 0 immediately; in_ready = 1 after release.
